// File: rtl/ps2_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : ps2_pkg                                                     |
// | Purpose : Shared types and constants for the PS/2 receive path:       |
// |           frame FSM state encoding and frame length.                  |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package ps2_pkg;

  // Frame phases: waiting for start bit, 8 data bits, parity, stop.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : sync_fifo                                                   |
// | Purpose : Single-clock power-of-two FIFO with first-word fall-through |
// |           head. A push into a full FIFO is accepted only when a pop   |
// |           happens in the same cycle; otherwise it is ignored.         |
// | Ports   : clk, rst (async, active-high)                               |
// |           push/wdata  - write request and byte                        |
// |           pop         - read request (ignored when empty)             |
// |           rdata       - head entry                                    |
// |           full/empty/count - occupancy                                |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                  c_ADDR_W = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0]   c_FULL   = (c_ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;
  logic                w_push_ok;
  logic                w_pop_ok;

  assign full  = (r_count == c_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // A pop on a full FIFO frees the slot the push needs in the same cycle.
  assign w_push_ok = push & (~full | pop);
  assign w_pop_ok  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; contents are only observable while non-empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : ps2_rx_fifo                                                 |
// | Purpose : PS/2 device-to-host receiver. Synchronises and glitch-      |
// |           filters ps2_clk, decodes 11-bit frames on filtered falling  |
// |           edges, flags parity/framing/overflow errors, aborts stalled |
// |           frames and buffers good bytes in a FWFT FIFO.               |
// | Ports   : clk, rst (async, active-high)                               |
// |           ps2_clk, ps2_data   - raw PS/2 pins                         |
// |           rx_data/rx_valid/rx_ready - byte stream out (valid/ready)   |
// |           fill_level          - FIFO occupancy                        |
// |           overflow, parity_err, frame_err - sticky error flags        |
// |           err_clr             - clears the sticky flags               |
// |           sample_stb          - pulse per accepted falling edge       |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic                     parity_err,
  output logic                     frame_err,
  input  logic                     err_clr,
  output logic                     sample_stb
);

  localparam int                c_FILT_W    = $clog2(FILTER_LEN + 1);
  localparam int                c_TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_LEN - 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]          r_clk_sync;
  logic [1:0]          r_data_sync;
  logic                r_filt;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                r_sample_stb;
  logic                r_sample_bit;
  logic                w_diff;
  logic                w_flip;
  logic                w_fall;

  ps2_state_e          r_state;
  ps2_state_e          w_state_nxt;
  logic [7:0]          r_shift;
  logic [2:0]          r_bit_cnt;
  logic                r_par;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic                w_timeout;
  logic                w_push_req;
  logic                w_ferr_evt;
  logic                w_perr_evt;
  logic                w_push_ok;
  logic                w_full;
  logic                w_empty;

  // ---------------- synchronisers and clock filter ----------------------
  // The filter counts consecutive cycles where the synced clock disagrees
  // with the filtered level; the level flips on the FILTER_LEN-th one.
  assign w_diff = r_clk_sync[1] ^ r_filt;
  assign w_flip = w_diff && (r_filt_cnt == c_FILT_LAST);
  assign w_fall = w_flip && !r_clk_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync   <= 2'b11;
      r_data_sync  <= 2'b11;
      r_filt       <= 1'b1;
      r_filt_cnt   <= '0;
      r_sample_stb <= 1'b0;
      r_sample_bit <= 1'b1;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], ps2_clk};
      r_data_sync  <= {r_data_sync[0], ps2_data};
      if (w_flip) begin
        r_filt     <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else if (w_diff) begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end else begin
        r_filt_cnt <= '0;
      end
      r_sample_stb <= w_fall;
      if (w_fall) r_sample_bit <= r_data_sync[1];
    end
  end

  assign sample_stb = r_sample_stb;

  // ---------------- frame FSM ------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Stalled frames are aborted when no edge arrives for TIMEOUT_CYC cycles.
  assign w_timeout = (r_state != ST_IDLE) && !r_sample_stb && (r_to_cnt == c_TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_ferr_evt  = 1'b0;
    w_perr_evt  = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_ferr_evt  = 1'b1;
    end else if (r_sample_stb) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!r_sample_bit) w_state_nxt = ST_DATA;
          else               w_ferr_evt  = 1'b1;
        end
        ST_DATA: begin
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          // A bad stop bit is reported as framing even if parity is also bad.
          if (!r_sample_bit)           w_ferr_evt = 1'b1;
          else if (^{r_shift, r_par})  w_push_req = 1'b1;
          else                         w_perr_evt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (r_sample_stb) begin
        unique case (r_state)
          ST_IDLE:   r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {r_sample_bit, r_shift[7:1]};   // LSB arrives first
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          ST_PARITY: r_par <= r_sample_bit;
          ST_STOP:   r_bit_cnt <= '0;
        endcase
      end
      if ((r_state == ST_IDLE) || r_sample_stb) r_to_cnt <= '0;
      else                                      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // ---------------- sticky flags ---------------------------------------
  // A new event in the same cycle as err_clr keeps the flag set.
  assign w_push_ok = w_push_req & (~w_full | rx_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (w_push_req && !w_push_ok) overflow <= 1'b1;
      else if (err_clr)             overflow <= 1'b0;
      if (w_perr_evt)               parity_err <= 1'b1;
      else if (err_clr)             parity_err <= 1'b0;
      if (w_ferr_evt)               frame_err <= 1'b1;
      else if (err_clr)             frame_err <= 1'b0;
    end
  end

  // ---------------- output FIFO ----------------------------------------
  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .wdata (r_shift),
    .pop   (rx_ready),
    .rdata (rx_data),
    .full  (w_full),
    .empty (w_empty),
    .count (fill_level)
  );

  assign rx_valid = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_ps2_rx_fifo                                              |
// | Purpose : Self-checking bench for ps2_rx_fifo: table of single-frame  |
// |           vectors plus hand-written multi-frame sequences.            |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH       = 8;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF_BIT    = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] fill_level;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;
  logic       err_clr;
  logic       sample_stb;

  int n_checks = 0;
  int n_errs   = 0;
  int stb_cnt  = 0;

  ps2_rx_fifo #(
    .DEPTH       (DEPTH),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fill_level (fill_level),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_clr    (err_clr),
    .sample_stb (sample_stb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sample_stb) stb_cnt <= stb_cnt + 1;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clr_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // mode 0: plain; 1: check latency around the stop-bit strobe;
  // 2: assert rx_ready in the stop-bit strobe cycle (push+pop together).
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int nbits, input logic glitch, input int mode);
    logic [10:0] f;
    int          seen;
    f    = {stop, par, data, 1'b0};
    seen = 0;
    for (int b = 0; b < nbits; b++) begin
      ps2_data = f[b];
      for (int i = 0; i < HALF_BIT; i++) begin
        ps2_clk = !(glitch && i == 5);
        @(negedge clk);
      end
      for (int i = 0; i < HALF_BIT; i++) begin
        ps2_clk = glitch && i == 9;
        @(negedge clk);
        if (rx_ready) rx_ready = 1'b0;
        if (b == 10 && mode != 0) begin
          if (seen == 1) begin
            if (mode == 1) begin
              chk("latency_valid_after", rx_valid, 1);
              chk("latency_data_after", rx_data, data);
            end else begin
              chk("fullpop_fill", fill_level, DEPTH);
              chk("fullpop_overflow", overflow, 0);
            end
            seen = 2;
          end else if (seen == 0 && sample_stb) begin
            seen = 1;
            if (mode == 1) chk("latency_valid_at_stb", rx_valid, 0);
            else           rx_ready = 1'b1;
          end
        end
      end
    end
    if (mode != 0 && seen != 2) chk("stop_strobe_seen", seen, 2);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(4);
  endtask

  logic [7:0] ovf_par;
  logic [7:0] fp_par;
  logic [7:0] exp_q[$];
  int         s0;

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    // odd-parity bits for bytes 0x01..0x09 (bit i-1) and 0x11..0x18 (bit i-1)
    ovf_par = 8'b0011_0100;   // 0x01..0x08: 0,0,1,0,1,1,0,0
    fp_par  = 8'b1100_1011;   // 0x11..0x18: 1,1,0,1,0,0,1,1

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    tick(3);
    chk("reset_valid", rx_valid, 0);
    chk("reset_fill", fill_level, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_perr", parity_err, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_stb", sample_stb, 0);
    rst = 1'b0;
    tick(5);

    // first byte with latency check
    send_frame(8'h1C, 1'b0, 1'b1, PS2_FRAME_BITS, 1'b0, 1);
    chk("first_data", rx_data, 8'h1C);
    chk("first_fill", fill_level, 1);
    chk("first_flags", {overflow, parity_err, frame_err}, 0);
    pop1();
    chk("first_pop_fill", fill_level, 0);

    // table-driven single frames
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, PS2_FRAME_BITS, 1'b0, 0);
      chk($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_fill", v), fill_level, vecs[v].exp_valid);
      if (vecs[v].exp_valid) chk($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
      chk($sformatf("vec%0d_perr", v), parity_err, vecs[v].exp_perr);
      chk($sformatf("vec%0d_ferr", v), frame_err, vecs[v].exp_ferr);
      if (vecs[v].exp_valid) pop1();
      clr_errs();
      chk($sformatf("vec%0d_cleared", v), {parity_err, frame_err}, 0);
    end

    // glitches on ps2_clk shorter than the filter window
    s0 = stb_cnt;
    send_frame(8'h5A, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b1, 0);
    chk("glitch_strobes", stb_cnt - s0, PS2_FRAME_BITS);
    chk("glitch_data", rx_data, 8'h5A);
    chk("glitch_flags", {parity_err, frame_err}, 0);
    pop1();

    // stall after start + 5 data bits
    send_frame(8'h3C, 1'b0, 1'b1, 6, 1'b0, 0);
    chk("pre_timeout_ferr", frame_err, 0);
    tick(TIMEOUT_CYC + 20);
    chk("timeout_ferr", frame_err, 1);
    chk("timeout_fill", fill_level, 0);
    clr_errs();
    send_frame(8'hF0, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0, 0);
    chk("after_timeout_data", rx_data, 8'hF0);
    chk("after_timeout_fill", fill_level, 1);
    chk("after_timeout_ferr", frame_err, 0);
    pop1();

    // overflow: nine good frames, no pops
    for (int i = 1; i <= 9; i++)
      send_frame(8'(i), (i == 9) ? 1'b1 : ovf_par[i-1], 1'b1, PS2_FRAME_BITS, 1'b0, 0);
    chk("ovf_fill", fill_level, DEPTH);
    chk("ovf_flag", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), rx_data, i);
      pop1();
    end
    chk("ovf_drained_valid", rx_valid, 0);
    clr_errs();
    chk("ovf_cleared", overflow, 0);

    // full FIFO + push and pop in the same cycle
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h11 + 8'(i), fp_par[i], 1'b1, PS2_FRAME_BITS, 1'b0, 0);
      exp_q.push_back(8'h11 + 8'(i));
    end
    chk("fp_fill_before", fill_level, DEPTH);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0, 2);
    chk("fp_overflow_after", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fp_pop%0d", i), rx_data, exp_q[i]);
      pop1();
    end
    chk("fp_drained_fill", fill_level, 0);

    // reset in the middle of a frame
    send_frame(8'h42, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0, 0);
    send_frame(8'h1C, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0, 0);
    chk("prerst_fill", fill_level, 1);
    chk("prerst_perr", parity_err, 1);
    send_frame(8'h77, 1'b0, 1'b1, 4, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_fill", fill_level, 0);
    chk("midrst_flags", {overflow, parity_err, frame_err}, 0);
    chk("midrst_stb", sample_stb, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    send_frame(8'hF0, 1'b1, 1'b1, PS2_FRAME_BITS, 1'b0, 0);
    chk("postrst_data", rx_data, 8'hF0);
    chk("postrst_fill", fill_level, 1);
    chk("postrst_flags", {overflow, parity_err, frame_err}, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
